// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// controller state encoding, line geometry and the address-field helper.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    FILL
  } state_e;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int MEM_ADDR_W = 28;

  // Fields of a CPU byte address. Index and tag are returned right-aligned
  // at full width; callers keep only the low IDX_W / TAG_W bits.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [1:0]  word;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [31:0] addr,
                                              input int          idx_w);
    addr_fields_t f;
    f.word  = addr[3:2];
    f.index = (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    f.tag   = addr >> (OFFSET_W + idx_w);
    return f;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Bus bundle for icache_ctrl: CPU fetch port plus the block-read port
// towards instruction memory. "slave" is the cache's view, "master" the
// view of the surrounding CPU/memory environment.
interface icache_if #(
  parameter int ADDR_W = 32
);
  import icache_pkg::*;

  logic                  read;
  logic [ADDR_W-1:0]     address;
  logic [31:0]           instruction;
  logic                  busywait;
  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [127:0]          mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  read, address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output read, address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );

endinterface

// File: rtl/icache_line_array.sv
// Line storage for the instruction cache: valid bits (async cleared),
// tags and 128-bit data, one write port and one combinational read port.
module icache_line_array #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [127:0]     wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [127:0]     rd_data_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  // Valid bits: cleared on reset, set when a line is filled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload for the line being filled.
  // NOTE: storage arrays carry no reset; valid_q alone decides whether their
  // contents mean anything, and leaving them unreset keeps them RAM-mappable.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller. Hits return the
// addressed word combinationally; misses run a block read
// (MEM_REQ -> MEM_WAIT -> FILL) and the fetch hits the cycle after FILL.
// Optional build macro ICACHE_PERF_CNT_EN adds hit_count/miss_count ports.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int ADDR_W    = 32
) (
  input  logic        clock,
  input  logic        reset,
  icache_if.slave     bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] mem_address_q, mem_address_d;

  addr_fields_t     fields;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [127:0]     line_data;
  logic [31:0]      line_word;
  logic             hit;
  logic             unused_bits;

  assign fields      = split_addr(32'(bus.address), IDX_W);
  assign cur_idx     = fields.index[IDX_W-1:0];
  assign cur_tag     = fields.tag[TAG_W-1:0];
  assign unused_bits = ^{fields.tag[31:TAG_W], fields.index[31:IDX_W],
                         bus.address[1:0]};

  // The pending fill targets the registered block address, so the CPU may
  // change or drop its request mid-miss without redirecting the fill.
  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (state_q == FILL),
    .wr_idx_i   (mem_address_q[IDX_W-1:0]),
    .wr_tag_i   (mem_address_q[IDX_W +: TAG_W]),
    .wr_data_i  (bus.mem_readdata),
    .rd_idx_i   (cur_idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data)
  );

  assign hit       = line_valid && (line_tag == cur_tag);
  assign line_word = line_data[{fields.word, 5'b0} +: 32];

  // State and block-address registers; reset aborts any fill in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
    end
  end

  // Next-state logic; the block address is captured only when a miss starts.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read && !hit) begin
          state_d       = MEM_REQ;
          mem_address_d = bus.address[OFFSET_W +: MEM_ADDR_W];
        end
      end
      // Low mem_busywait here is the memory's idle report from before it
      // sampled the request, so only a rising busywait advances.
      MEM_REQ:  if (bus.mem_busywait)  state_d = MEM_WAIT;
      MEM_WAIT: if (!bus.mem_busywait) state_d = FILL;
      FILL:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // CPU and memory handshake outputs decoded from the current state.
  always_comb begin
    bus.busywait    = 1'b1;
    bus.instruction = '0;
    bus.mem_read    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.busywait    = bus.read && !hit;
        bus.instruction = hit ? line_word : 32'h0;
      end
      MEM_REQ, MEM_WAIT: bus.mem_read = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_address = mem_address_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Hit/miss event counters; both wrap naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == IDLE && bus.read) begin
      if (hit) hit_count_q  <= hit_count_q + 32'd1;
      else     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl: cold miss, hits, conflict miss,
// early-idle memory, dropped request, reset mid-fill and (with
// ICACHE_PERF_CNT_EN) the performance counters.
module tb_icache_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  icache_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_ctrl #(
    .NUM_LINES (8),
    .ADDR_W    (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory blocks, word3..word0.
  localparam logic [127:0] BLK0 = {32'h00318193, 32'h00210113, 32'h00000000, 32'h00108093};
  localparam logic [127:0] BLK8 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
  localparam logic [127:0] BLK3 = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Runs one complete miss. Precondition: FSM in IDLE, read=1 and
  // address=a already driven this cycle. The memory first reports idle for
  // idle_n cycles, then holds busywait for 16 clocks. Optionally the CPU
  // drops read and moves its address once the transfer is under way.
  task automatic run_miss(input logic [31:0] a, input logic [127:0] blk,
                          input int idle_n, input logic drop_read,
                          input logic [31:0] new_addr);
    settle();
    check("miss_busywait_idle", 32'(bus.busywait), 32'd1);
    check("miss_mem_read_idle", 32'(bus.mem_read), 32'd0);
    tick();  // MEM_REQ
    check("req_mem_read", 32'(bus.mem_read), 32'd1);
    check("req_mem_address", {4'h0, bus.mem_address}, {4'h0, a[31:4]});
    check("req_busywait", 32'(bus.busywait), 32'd1);
    for (int i = 0; i < idle_n; i++) begin
      tick();
      check("early_idle_mem_read", 32'(bus.mem_read), 32'd1);
      check("early_idle_busywait", 32'(bus.busywait), 32'd1);
    end
    bus.mem_busywait = 1'b1;
    tick();  // MEM_WAIT
    if (drop_read) begin
      bus.read    = 1'b0;
      bus.address = new_addr;
    end
    repeat (15) tick();
    check("wait_mem_read", 32'(bus.mem_read), 32'd1);
    check("wait_busywait", 32'(bus.busywait), 32'd1);
    check("wait_mem_address", {4'h0, bus.mem_address}, {4'h0, a[31:4]});
    bus.mem_readdata = blk;
    bus.mem_busywait = 1'b0;
    tick();  // FILL
    check("fill_mem_read", 32'(bus.mem_read), 32'd0);
    check("fill_busywait", 32'(bus.busywait), 32'd1);
    tick();  // IDLE, line now resident
    bus.mem_readdata = ~blk;
    settle();
    if (!drop_read) begin
      check("post_fill_busywait", 32'(bus.busywait), 32'd0);
      check("post_fill_instruction", bus.instruction, blk[{a[3:2], 5'b0} +: 32]);
    end else begin
      check("dropped_read_busywait", 32'(bus.busywait), 32'd0);
    end
    check("post_fill_mem_read", 32'(bus.mem_read), 32'd0);
  endtask

  // Hit table: (address, expected instruction) after BLK0 is resident.
  logic [31:0] hit_addr [4] = '{32'h00000008, 32'h0000000C, 32'h0000000D, 32'h00000002};
  logic [31:0] hit_inst [4] = '{32'h00210113, 32'h00318193, 32'h00318193, 32'h00108093};

  initial begin
    bus.read         = 1'b0;
    bus.address      = '0;
    bus.mem_readdata = '0;
    bus.mem_busywait = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_busywait", 32'(bus.busywait), 32'd0);
    check("rst_instruction", bus.instruction, 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_address", {4'h0, bus.mem_address}, 32'd0);
    reset = 1'b0;
    tick();

    // Cold miss on block 0.
    bus.read    = 1'b1;
    bus.address = 32'h00000000;
    run_miss(32'h00000000, BLK0, 0, 1'b0, 32'h0);

    // Hit on word 1 in the same cycle.
    bus.address = 32'h00000004;
    settle();
    check("hit4_busywait", 32'(bus.busywait), 32'd0);
    check("hit4_instruction", bus.instruction, 32'h00000000);
    check("hit4_mem_read", 32'(bus.mem_read), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.address = hit_addr[i];
      settle();
      check("hit_tbl_busywait", 32'(bus.busywait), 32'd0);
      check("hit_tbl_instruction", bus.instruction, hit_inst[i]);
    end

    // No request in IDLE.
    bus.read = 1'b0;
    settle();
    check("noread_busywait", 32'(bus.busywait), 32'd0);
    tick();
    check("noread_mem_read", 32'(bus.mem_read), 32'd0);

    // Conflict: index 0 tag 1 evicts block 0, then block 0 evicts it back.
    bus.read    = 1'b1;
    bus.address = 32'h00000080;
    run_miss(32'h00000080, BLK8, 0, 1'b0, 32'h0);
    bus.address = 32'h00000084;
    settle();
    check("conf_hit84", bus.instruction, 32'hCAFE0001);
    tick();
    bus.address = 32'h00000000;
    run_miss(32'h00000000, BLK0, 0, 1'b0, 32'h0);
    bus.address = 32'h00000080;
    settle();
    check("conf_evicted_busywait", 32'(bus.busywait), 32'd1);
    bus.address = 32'h0000000C;
    settle();
    check("conf_valid_busywait", 32'(bus.busywait), 32'd0);
    check("conf_valid_instruction", bus.instruction, 32'h00318193);

    // Early-idle memory, with the CPU dropping read and moving address.
    tick();
    bus.address = 32'h00000030;
    run_miss(32'h00000030, BLK3, 3, 1'b1, 32'h00000044);
    tick();
    bus.read    = 1'b1;
    bus.address = 32'h00000038;
    settle();
    check("drop_fill_busywait", 32'(bus.busywait), 32'd0);
    check("drop_fill_instruction", bus.instruction, 32'h33330002);
    bus.address = 32'h00000044;
    settle();
    check("drop_other_line_busywait", 32'(bus.busywait), 32'd1);

    // Reset in MEM_WAIT.
    tick();  // MEM_REQ for 0x44
    check("rstmid_req_mem_read", 32'(bus.mem_read), 32'd1);
    bus.mem_busywait = 1'b1;
    tick();  // MEM_WAIT
    repeat (4) tick();
    reset = 1'b1;
    settle();
    check("rstmid_mem_read", 32'(bus.mem_read), 32'd0);
    check("rstmid_mem_address", {4'h0, bus.mem_address}, 32'd0);
    bus.mem_busywait = 1'b0;
    tick();
    reset = 1'b0;
    bus.address = 32'h00000000;
    settle();
    check("rstmid_remiss0_busywait", 32'(bus.busywait), 32'd1);
    bus.address = 32'h00000044;
    settle();
    check("rstmid_remiss44_busywait", 32'(bus.busywait), 32'd1);

    // Miss, hit, hit, miss (counters restart from the reset above).
    bus.address = 32'h00000000;
    run_miss(32'h00000000, BLK0, 0, 1'b0, 32'h0);
    tick();
    bus.address = 32'h00000004;
    settle();
    check("seq_hit_busywait", 32'(bus.busywait), 32'd0);
    tick();
    bus.address = 32'h00000080;
    settle();
    check("seq_miss_busywait", 32'(bus.busywait), 32'd1);
    tick();  // MEM_REQ
    check("seq_miss_mem_address", {4'h0, bus.mem_address}, 32'h00000008);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_count", hit_count, 32'd2);
    check("perf_miss_count", miss_count, 32'd2);
`endif
    bus.read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the 128-bit block instruction memory.
- On a hit, it returns a 32-bit instruction combinationally.
- On a miss, it acts as the initiator of the memory block-read handshake: drive `mem_read` and `mem_address`, wait for `mem_busywait` to rise and then fall, fill the line, then serve the fetch.

Parameters:
- NUM_LINES, 8, number of 16-byte lines (power of 2); index width IDX_W = log2(NUM_LINES).
- ADDR_W, 32, CPU byte-address width; tag width = ADDR_W - 4 - IDX_W.

Ports:
- clock  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-high; clears all state
- read  input  1  CPU fetch request, held until busywait low
- address  input  ADDR_W  CPU byte address; bits [1:0] ignored
- instruction  output  32  fetched instruction, valid when read=1 and busywait=0
- busywait  output  1  stall to CPU
- mem_read  output  1  block read request to instruction memory
- mem_address  output  28  block address = address[31:4]
- mem_readdata  input  128  block data; byte k of block at bits [8k+7:8k]
- mem_busywait  input  1  memory busy; falls when mem_readdata is complete

Behaviour:
- Address split:
  - word offset = address[3:2]
  - index = address[4+IDX_W-1:4]
  - tag = upper bits
- Storage: per line a valid bit, a tag, and 128-bit data.
- Word selection: word w = data[32w+31:32w].
- hit = valid[index] && tag match.
- Outputs while in IDLE (combinational):
  - busywait = read && !hit
  - instruction = selected word on hit, else 0
- When not in IDLE, busywait = 1.
- FSM states, registered, async reset to IDLE:
  - IDLE:
    - read && !hit -> MEM_REQ
    - otherwise stay in IDLE
  - MEM_REQ:
    - mem_read=1, mem_address=address[31:4]
    - mem_busywait=1 -> MEM_WAIT
    - mem_busywait low in this state is ignored, because the memory reports idle before it samples the request.
  - MEM_WAIT:
    - mem_read=1
    - mem_busywait=0 -> FILL
  - FILL:
    - mem_read=0
    - Line written on this edge: data[index] <= mem_readdata, tag[index] <= tag, valid[index] <= 1.
    - Next state -> IDLE.
    - The fetch then hits in IDLE the following cycle.
    - mem_read must be low for at least this cycle so the memory clears its finished flag before the next request.
- Miss latency:
  - Request cycle + 1 cycle to MEM_REQ, + memory transfer time (16 clocks for the current memory), + FILL + 1 IDLE hit cycle.
  - busywait stays 1 throughout.
- mem_address is registered at the IDLE->MEM_REQ transition and held constant until FILL.
- address changing while not in IDLE does not alter the pending fill.
- Boundary conditions:
  - read=0 in IDLE: busywait=0, mem_read=0.
  - read dropped mid-miss: the fill still completes; no abort.
  - Conflict miss (same index, different tag): the line is overwritten; no victim writeback, since the cache is read-only.
- Reset values:
  - busywait = 0 (when read=0), instruction = 0, mem_read = 0, mem_address = 0.
  - All valid bits = 0. Tag and data contents are don't-care.
- Reset mid-operation returns to IDLE immediately and drops mem_read.
  - The partially fetched line is not written.
  - The next access re-misses.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined, add two output ports:
  - hit_count (32 bits): increments on each IDLE cycle with read && hit.
  - miss_count (32 bits): increments on each IDLE->MEM_REQ transition.
- Both counters are cleared by reset and wrap at 2^32.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `icache_pkg` holds:
  - state enum: IDLE, MEM_REQ, MEM_WAIT, FILL
  - constants: LINE_BYTES=16, OFFSET_W=4, MEM_ADDR_W=28
  - the address-field slicing helper
- One natural sub-module, `icache_line_array`: valid/tag/data storage with an async clear of the valid bits, a single write port, and a combinational read port.

Test Plan:
- Cold miss:
  - Stimulus: reset, then read=1, address=0x00000000, memory block 0 word0=0x00108093.
  - Expected: mem_read=1 and mem_address=0; busywait=1 until the fill; instruction=0x00108093 one cycle after FILL; mem_read=0 in FILL.
- Hit after fill:
  - Stimulus: read address=0x00000004 immediately after the cold miss.
  - Expected: busywait=0 in the same cycle, instruction=0x00000000, mem_read stays 0.
- Conflict miss (NUM_LINES=8):
  - Stimulus: read 0x00000080 (index 0, tag 1), then read 0x00000000.
  - Expected: both miss with mem_address 0x0000008 and 0x0000000 respectively; valid[0] is retained.
- Early-idle immunity:
  - Stimulus: hold mem_busywait=0 for 3 cycles after mem_read rises, then run the memory sequence.
  - Expected: FSM stays in MEM_REQ; no premature fill.
- Reset mid-fill:
  - Stimulus: assert reset during MEM_WAIT.
  - Expected: mem_read=0 asynchronously; re-reading 0x00000000 misses again.
- Perf counters (with ICACHE_PERF_CNT_EN):
  - Stimulus: the sequence miss, hit, hit, miss.
  - Expected: hit_count=2, miss_count=2.
